logic_unit_arbiter: RTL
=======================

// Module: logic_unit_arbiter
// PURPOSE
//  Shares one AND/XOR/OR logic datapath between two requesters (req0 = EXU
//  issue, req1 = auxiliary/CSR path). Round-robin arbitration, valid/ready
//  handshakes, and a one-entry registered response buffer with backpressure.
//  Sits between issue logic and the logic-op datapath; has saturating
//  per-requester issue counters for perf monitoring.
// PARAMETERS
//  XLEN   64  operand/result width
//  TAG_W  4   requester-supplied tag, returned unchanged with result
//  CNT_W  32  width of each issue counter
// PORTS
//  clk         in   1      clock, all state on rising edge
//  rst_n       in   1      asynchronous active-low reset
//  r0_valid    in   1      req0 presents an op
//  r0_ready    out  1      req0 op accepted this cycle when high with r0_valid
//  r0_src1     in   XLEN   req0 operand 1
//  r0_src2     in   XLEN   req0 operand 2
//  r0_op       in   2      00 AND, 01 XOR, 10 OR, 11 reserved (result 0)
//  r0_tag      in   TAG_W  req0 tag
//  r1_*        --   --     identical set for req1 (valid/ready/src1/src2/op/tag)
//  rsp_valid   out  1      response register holds a result
//  rsp_ready   in   1      consumer takes response this cycle
//  rsp_id      out  1      0 = from req0, 1 = from req1
//  rsp_tag     out  TAG_W  tag of the accepted request
//  rsp_result  out  XLEN   logic result
//  clr_cnt     in   1      synchronous clear of both counters
//  cnt0/cnt1   out  CNT_W  accepted-op counts per requester, saturating
// BEHAVIOUR
//  - Reset: rsp_valid=0, rsp_id=0, rsp_tag=0, rsp_result=0, cnt0=cnt1=0,
//    rr pointer last_grant=1 (req0 wins first contention).
//  - can_accept = !rsp_valid | rsp_ready (buffer empty or draining this cycle).
//  - Grant (combinational): only r0_valid -> 0; only r1_valid -> 1; both ->
//    !last_grant; none -> no grant. rX_ready = can_accept & grant==X;
//    loser's ready is 0. Ready may depend on valid; valid must not depend on ready.
//  - Accept (rX_valid & rX_ready): next edge loads rsp_result = op(src1,src2),
//    rsp_id = X, rsp_tag = rX_tag, rsp_valid = 1, last_grant = X.
//  - Latency: exactly 1 cycle accept->rsp_valid; throughput 1 op/cycle when
//    rsp_ready held high.
//  - Stall: rsp_valid & !rsp_ready -> rsp_* held stable, both readys 0,
//    last_grant unchanged.
//  - Drain w/o accept: rsp_valid -> 0; rsp_id/tag/result keep old values.
//  - Drain + accept same cycle: new result loaded, rsp_valid stays 1.
//  - Requester dropping valid before handshake: no state change.
//  - op 2'b11: accepted normally, rsp_result = 0, counted.
//  - Counters: +1 on each accept of that requester; hold at 2^CNT_W-1;
//    clr_cnt zeroes both, clear wins over simultaneous increment.
//  - rst_n low mid-transaction: pending response discarded immediately
//    (async), readys drop to 0 while rst_n low.
// TESTING
//  1 Reset: rst_n=0 with r0/r1 valid -> readys 0, rsp_valid 0, cnt 0.
//  2 Single op: r0 AND 0xF0F0..., 0xFF00... tag 3, rsp_ready=1 -> next cycle
//    rsp_valid=1, result 0xF000..., id 0, tag 3; cnt0=1.
//  3 Contention: both valid 4 cycles, rsp_ready=1 -> grants 0,1,0,1; cnt0=cnt1=2.
//  4 Backpressure: rsp_ready=0 for 3 cycles after accept -> rsp_* stable,
//    readys 0; raise rsp_ready with r1 XOR 0xA5,0x0F pending -> same-cycle
//    drain+accept, next rsp = 0xAA, id 1, rsp_valid never drops.
//  5 Ops: OR 0x1,0x2 -> 0x3; op 11 with 0xFF,0xFF -> 0x0.
//  6 Counters: CNT_W=2, 5 req0 accepts -> cnt0=3; clr_cnt with accept -> 0.

Source files
------------

// File: rtl/logic_unit_arbiter_if.sv
// ----------------------------------------------------------------------------
// logic_unit_arbiter_if
//   Bundles the two requester channels, the response channel and the
//   perf-counter signals of logic_unit_arbiter.
//   master : requester/consumer side (drives valids, operands, rsp_ready, clr)
//   slave  : arbiter side (drives readys, response, counters)
// ----------------------------------------------------------------------------
interface logic_unit_arbiter_if #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 4,
  parameter int CNT_W = 32
);
  // requester 0 (EXU issue)
  logic             r0_valid;
  logic             r0_ready;
  logic [XLEN-1:0]  r0_src1;
  logic [XLEN-1:0]  r0_src2;
  logic [1:0]       r0_op;
  logic [TAG_W-1:0] r0_tag;
  // requester 1 (aux / CSR path)
  logic             r1_valid;
  logic             r1_ready;
  logic [XLEN-1:0]  r1_src1;
  logic [XLEN-1:0]  r1_src2;
  logic [1:0]       r1_op;
  logic [TAG_W-1:0] r1_tag;
  // response
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [TAG_W-1:0] rsp_tag;
  logic [XLEN-1:0]  rsp_result;
  // perf counters
  logic             clr_cnt;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  modport master (
    output r0_valid, r0_src1, r0_src2, r0_op, r0_tag,
    output r1_valid, r1_src1, r1_src2, r1_op, r1_tag,
    output rsp_ready, clr_cnt,
    input  r0_ready, r1_ready,
    input  rsp_valid, rsp_id, rsp_tag, rsp_result,
    input  cnt0, cnt1
  );

  modport slave (
    input  r0_valid, r0_src1, r0_src2, r0_op, r0_tag,
    input  r1_valid, r1_src1, r1_src2, r1_op, r1_tag,
    input  rsp_ready, clr_cnt,
    output r0_ready, r1_ready,
    output rsp_valid, rsp_id, rsp_tag, rsp_result,
    output cnt0, cnt1
  );
endinterface

// File: rtl/logic_unit_arbiter.sv
// ----------------------------------------------------------------------------
// logic_unit_arbiter
//   Shares one AND/XOR/OR datapath between two requesters with round-robin
//   arbitration, a one-entry registered response buffer with backpressure,
//   and saturating per-requester accept counters.
//   Ports:
//     clk    : clock, all state on rising edge
//     rst_n  : asynchronous active-low reset
//     bus    : logic_unit_arbiter_if.slave
//              r0_*/r1_*  request channels (valid/ready/src1/src2/op/tag)
//              rsp_*      response channel (valid/ready/id/tag/result)
//              clr_cnt    synchronous clear of both counters
//              cnt0/cnt1  saturating accept counts
// ----------------------------------------------------------------------------

// Saturating up-counter with synchronous clear (clear beats increment).
module lua_sat_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                          cnt_d = '0;
    else if (inc && cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

module logic_unit_arbiter #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 4,
  parameter int CNT_W = 32
) (
  input logic                 clk,
  input logic                 rst_n,
  logic_unit_arbiter_if.slave bus
);
  localparam int NUM_REQ = 2;

  // Requester channels gathered into packed arrays so selection is an index.
  logic [NUM_REQ-1:0]            req_vld;
  logic [NUM_REQ-1:0][XLEN-1:0]  req_s1;
  logic [NUM_REQ-1:0][XLEN-1:0]  req_s2;
  logic [NUM_REQ-1:0][1:0]       req_op;
  logic [NUM_REQ-1:0][TAG_W-1:0] req_tag;

  assign req_vld = {bus.r1_valid, bus.r0_valid};
  assign req_s1  = {bus.r1_src1,  bus.r0_src1};
  assign req_s2  = {bus.r1_src2,  bus.r0_src2};
  assign req_op  = {bus.r1_op,    bus.r0_op};
  assign req_tag = {bus.r1_tag,   bus.r0_tag};

  // Response buffer and round-robin pointer.
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q,    rsp_id_d;
  logic [TAG_W-1:0] rsp_tag_q,   rsp_tag_d;
  logic [XLEN-1:0]  rsp_res_q,   rsp_res_d;
  logic             last_grant_q, last_grant_d;

  logic               can_accept;
  logic               gnt_any;
  logic               gnt_id;
  logic [NUM_REQ-1:0] rdy;
  logic               accept;
  logic [XLEN-1:0]    op_res;

  function automatic logic [XLEN-1:0] lop(input logic [1:0]      op,
                                          input logic [XLEN-1:0] a,
                                          input logic [XLEN-1:0] b);
    case (op)
      2'b00:   lop = a & b;
      2'b01:   lop = a ^ b;
      2'b10:   lop = a | b;
      default: lop = '0;   // reserved encoding still completes, with zero
    endcase
  endfunction

  // Buffer can take a new result if empty or being drained this cycle.
  assign can_accept = !rsp_valid_q || bus.rsp_ready;

  // Grant: sole requester wins; on contention the one not granted last wins.
  always_comb begin
    gnt_any = |req_vld;
    gnt_id  = 1'b0;
    case (req_vld)
      2'b01:   gnt_id = 1'b0;
      2'b10:   gnt_id = 1'b1;
      2'b11:   gnt_id = !last_grant_q;
      default: gnt_id = 1'b0;
    endcase
  end

  // rst_n gates the readys so nothing handshakes while reset is asserted.
  always_comb begin
    rdy[0] = rst_n && can_accept && gnt_any && (gnt_id == 1'b0);
    rdy[1] = rst_n && can_accept && gnt_any && (gnt_id == 1'b1);
  end

  // A ready is only raised for a valid requester, so any ready is an accept.
  assign accept = |rdy;
  assign op_res = lop(req_op[gnt_id], req_s1[gnt_id], req_s2[gnt_id]);

  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_tag_d    = rsp_tag_q;
    rsp_res_d    = rsp_res_q;
    last_grant_d = last_grant_q;
    if (accept) begin
      rsp_valid_d  = 1'b1;
      rsp_id_d     = gnt_id;
      rsp_tag_d    = req_tag[gnt_id];
      rsp_res_d    = op_res;
      last_grant_d = gnt_id;
    end else if (bus.rsp_ready) begin
      // Drain without refill: payload is kept, only valid drops.
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_tag_q    <= '0;
      rsp_res_q    <= '0;
      last_grant_q <= 1'b1;   // req0 wins the first contention
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_tag_q    <= rsp_tag_d;
      rsp_res_q    <= rsp_res_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Per-requester perf counters.
  logic [NUM_REQ-1:0][CNT_W-1:0] cnt;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
    lua_sat_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (bus.clr_cnt),
      .inc   (rdy[i]),
      .cnt   (cnt[i])
    );
  end

  assign bus.r0_ready   = rdy[0];
  assign bus.r1_ready   = rdy[1];
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_tag    = rsp_tag_q;
  assign bus.rsp_result = rsp_res_q;
  assign bus.cnt0       = cnt[0];
  assign bus.cnt1       = cnt[1];
endmodule
